// File: rtl/alu8_core.sv
// Registered 8-bit ALU: 16 opcodes, one-cycle latency with a valid strobe.
// Define ALU8_FLAGS_EN to add registered zero/neg status outputs.
module alu8_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             Cout,
   output logic             out_valid
`ifdef ALU8_FLAGS_EN
   ,
   output logic             zero,
   output logic             neg
`endif
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV = 4'h3,
      OP_SHL  = 4'h4, OP_SHR  = 4'h5, OP_ROL  = 4'h6, OP_ROR = 4'h7,
      OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR = 4'hB,
      OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT   = 4'hE, OP_EQ  = 4'hF
   } op_e;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res;
   logic               res_c;

   assign sum  = {1'b0, A} + {1'b0, B};
   assign diff = {1'b0, A} - {1'b0, B};   // bit WIDTH is the borrow, i.e. A < B
   assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

   // NOTE: defaults first so every path assigns res/res_c and no latch is inferred.
   always_comb begin
      res   = '0;
      res_c = 1'b0;
      case (op_e'(sel))
         OP_ADD:  begin res = sum[WIDTH-1:0];  res_c = sum[WIDTH];  end
         OP_SUB:  begin res = diff[WIDTH-1:0]; res_c = diff[WIDTH]; end
         OP_MUL:  begin res = prod[WIDTH-1:0]; res_c = |prod[2*WIDTH-1:WIDTH]; end
         OP_DIV: begin
            if (B == '0) begin
               res   = '1;
               res_c = 1'b1;
            end else begin
               res = A / B;
            end
         end
         OP_SHL:  begin res = {A[WIDTH-2:0], 1'b0}; res_c = A[WIDTH-1]; end
         OP_SHR:  begin res = {1'b0, A[WIDTH-1:1]}; res_c = A[0];       end
         OP_ROL:  res = {A[WIDTH-2:0], A[WIDTH-1]};
         OP_ROR:  res = {A[0], A[WIDTH-1:1]};
         OP_AND:  res = A & B;
         OP_OR:   res = A | B;
         OP_XOR:  res = A ^ B;
         OP_NOR:  res = ~(A | B);
         OP_NAND: res = ~(A & B);
         OP_XNOR: res = ~(A ^ B);
         OP_GT:   res = WIDTH'(A > B);
         OP_EQ:   res = WIDTH'(A == B);
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all outputs update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         Cout      <= 1'b0;
         out_valid <= 1'b0;
`ifdef ALU8_FLAGS_EN
         zero      <= 1'b0;
         neg       <= 1'b0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out  <= res;
            Cout <= res_c;
`ifdef ALU8_FLAGS_EN
            zero <= (res == '0);
            neg  <= res[WIDTH-1];
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu8_core.sv
// Self-checking bench for alu8_core: directed vector table, reset/hold sequences
// and randomized traffic against an arithmetic reference model.
module tb_alu8_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic [3:0] sel = '0;
   logic [7:0] out;
   logic       Cout;
   logic       out_valid;
`ifdef ALU8_FLAGS_EN
   logic       zero;
   logic       neg;
`endif

   alu8_core dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .sel       (sel),
      .out       (out),
      .Cout      (Cout),
      .out_valid (out_valid)
`ifdef ALU8_FLAGS_EN
      ,
      .zero      (zero),
      .neg       (neg)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model state: what the outputs must show after the latest edge
   int m_out = 0;
   int m_c   = 0;
   int m_v   = 0;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_out;
      logic       exp_c;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model from the opcode definitions, using plain integer arithmetic.
   task automatic ref_alu(input int op, input int a, input int b, output int o, output int c);
      int t;
      c = 0;
      case (op)
         0: begin t = a + b; o = t % 256; c = int'(t > 255); end
         1: begin o = (a - b + 256) % 256; c = int'(a < b); end
         2: begin t = a * b; o = t % 256; c = int'(t > 255); end
         3: if (b == 0) begin o = 255; c = 1; end else o = a / b;
         4: begin o = (a * 2) % 256; c = int'(a >= 128); end
         5: begin o = a / 2; c = a % 2; end
         6: o = (a * 2) % 256 + a / 128;
         7: o = a / 2 + (a % 2) * 128;
         8: o = a & b;
         9: o = a | b;
         10: o = a ^ b;
         11: o = 255 - (a | b);
         12: o = 255 - (a & b);
         13: o = 255 - (a ^ b);
         14: o = int'(a > b);
         default: o = int'(a == b);
      endcase
   endtask

   // One clock: drive on the falling edge, update the model at the rising edge, check just after.
   task automatic cycle(input logic r, input logic v, input logic [3:0] s,
                        input logic [7:0] a, input logic [7:0] b, input string name);
      int o, c;
      @(negedge clk);
      rst = r; in_valid = v; sel = s; A = a; B = b;
      @(posedge clk);
      if (r) begin
         m_out = 0; m_c = 0; m_v = 0;
      end else begin
         m_v = int'(v);
         if (v) begin
            ref_alu(int'(s), int'(a), int'(b), o, c);
            m_out = o; m_c = c;
         end
      end
      #1;
      check({name, ".out"},       int'(out),       m_out);
      check({name, ".Cout"},      int'(Cout),      m_c);
      check({name, ".out_valid"}, int'(out_valid), m_v);
`ifdef ALU8_FLAGS_EN
      check({name, ".zero"}, int'(zero), int'(m_out == 0));
      check({name, ".neg"},  int'(neg),  int'(m_out >= 128));
`endif
   endtask

   initial begin
      tbl.push_back('{4'h0, 8'h20, 8'h12, 8'h32, 1'b0});
      tbl.push_back('{4'h0, 8'hFF, 8'h01, 8'h00, 1'b1});
      tbl.push_back('{4'h1, 8'h18, 8'h04, 8'h14, 1'b0});
      tbl.push_back('{4'h1, 8'h04, 8'h18, 8'hEC, 1'b1});
      tbl.push_back('{4'h2, 8'h02, 8'h24, 8'h48, 1'b0});
      tbl.push_back('{4'h2, 8'h10, 8'h10, 8'h00, 1'b1});
      tbl.push_back('{4'h3, 8'h04, 8'h80, 8'h00, 1'b0});
      tbl.push_back('{4'h3, 8'h09, 8'h00, 8'hFF, 1'b1});
      tbl.push_back('{4'h4, 8'h03, 8'h5A, 8'h06, 1'b0});
      tbl.push_back('{4'h4, 8'h81, 8'h00, 8'h02, 1'b1});
      tbl.push_back('{4'h5, 8'h14, 8'hFF, 8'h0A, 1'b0});
      tbl.push_back('{4'h6, 8'h04, 8'h00, 8'h08, 1'b0});
      tbl.push_back('{4'h6, 8'h80, 8'h00, 8'h01, 1'b0});
      tbl.push_back('{4'h7, 8'h20, 8'h00, 8'h10, 1'b0});
      tbl.push_back('{4'h7, 8'h01, 8'h00, 8'h80, 1'b0});
      tbl.push_back('{4'h8, 8'h41, 8'h19, 8'h01, 1'b0});
      tbl.push_back('{4'h9, 8'h44, 8'h0C, 8'h4C, 1'b0});
      tbl.push_back('{4'hB, 8'h06, 8'h10, 8'hE9, 1'b0});
      tbl.push_back('{4'hC, 8'h10, 8'h01, 8'hFF, 1'b0});
      tbl.push_back('{4'hD, 8'h02, 8'h03, 8'hFE, 1'b0});
      tbl.push_back('{4'hA, 8'h0F, 8'hFF, 8'hF0, 1'b0});
      tbl.push_back('{4'hE, 8'h14, 8'h02, 8'h01, 1'b0});
      tbl.push_back('{4'hE, 8'h02, 8'h02, 8'h00, 1'b0});
      tbl.push_back('{4'hF, 8'h30, 8'h04, 8'h00, 1'b0});
      tbl.push_back('{4'hF, 8'h55, 8'h55, 8'h01, 1'b0});

      // reset held two cycles with in_valid high: reset must win
      cycle(1'b1, 1'b1, 4'h0, 8'h12, 8'h34, "reset0");
      cycle(1'b1, 1'b1, 4'h9, 8'hFF, 8'hFF, "reset1");
      cycle(1'b0, 1'b1, 4'h0, 8'h01, 8'h02, "first_op");

      // directed table, issued back to back
      foreach (tbl[i]) begin
         cycle(1'b0, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i));
         check($sformatf("vec%0d.table_out", i), int'(out), int'(tbl[i].exp_out));
         check($sformatf("vec%0d.table_c", i), int'(Cout), int'(tbl[i].exp_c));
      end

      // idle cycles: last result must hold with out_valid low
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 4'h0, 8'hAA, 8'hBB, $sformatf("hold%0d", i));
         check($sformatf("hold%0d.held", i), int'(out), 8'h01);
      end

      // in-flight operation discarded by reset
      cycle(1'b0, 1'b1, 4'h0, 8'h10, 8'h20, "pre_rst");
      cycle(1'b1, 1'b1, 4'h1, 8'h00, 8'h01, "mid_rst");

`ifdef ALU8_FLAGS_EN
      cycle(1'b0, 1'b1, 4'h1, 8'h05, 8'h05, "flag_zero");
      check("flag_zero.zero_const", int'(zero), 1);
      cycle(1'b0, 1'b1, 4'h1, 8'h00, 8'h01, "flag_neg");
      check("flag_neg.neg_const", int'(neg), 1);
`endif

      // randomized traffic with sporadic idles and resets
      for (int i = 0; i < 400; i++) begin
         cycle(1'b0 | ($urandom_range(0, 29) == 0),
               logic'($urandom_range(0, 3) != 0),
               4'($urandom), 8'($urandom),
               ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
               $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
